// File: rtl/jump_redirect_ctrl_pkg.sv
// Shared types and constants for the jump/trap redirect controller.
// Supplies the address width and zero defaults when none are set.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

`ifndef ZERO
`define ZERO '0
`endif

package jump_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RDR_IDLE   = 2'd0,
        RDR_PEND   = 2'd1,
        RDR_REDIR  = 2'd2,
        RDR_SHADOW = 2'd3
    } rdr_state_e;

    localparam int CNT_W = 3;

    function automatic logic [CNT_W-1:0] shadow_len(input int n);
        return CNT_W'(n);
    endfunction

endpackage

// File: rtl/jump_redirect_ctrl_flush_shadow_cnt.sv
// Loadable down-counter for the post-redirect shadow window.
// Ports: clk, rst, load, load_val, en, cnt, last (cnt == 1).
module flush_shadow_cnt
    import jump_redirect_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= `ZERO;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/jump_redirect_ctrl.sv
// PC redirect / squash sequencer for taken jumps and trap vectors.
// Ports: clk_i, rst_i, ex_valid_i, jump_enable_i, jump_addr_i, trap_i,
//   trap_addr_i, hold_ex_i, hold_mem_i -> stall_o, stall_ex_o,
//   redirect_o, redirect_addr_o, flush_o, misalign_o.
// Optional: REDIRECT_ALIGN_CHECK_EN rejects jumps with addr[1:0] != 0.
module jump_redirect_ctrl
    import jump_redirect_ctrl_pkg::*;
#(
    parameter int AW           = `ADDR_WIDTH,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ex_valid_i,
    input  logic          jump_enable_i,
    input  logic [AW-1:0] jump_addr_i,
    input  logic          trap_i,
    input  logic [AW-1:0] trap_addr_i,
    input  logic          hold_ex_i,
    input  logic          hold_mem_i,
    output logic          stall_o,
    output logic          stall_ex_o,
    output logic          redirect_o,
    output logic [AW-1:0] redirect_addr_o,
    output logic          flush_o,
    output logic          misalign_o
);

    localparam logic [CNT_W-1:0] FLUSH_LD = shadow_len(FLUSH_CYCLES);

    rdr_state_e       state_q, state_d;
    logic [AW-1:0]    target_q, target_d;
    logic             cnt_load, cnt_en, cnt_last;
    logic [CNT_W-1:0] cnt_q;
    logic             hold, accept, bad_align, misalign_d;

    assign hold   = hold_ex_i | hold_mem_i;
    assign accept = (state_q == RDR_IDLE) & ex_valid_i & jump_enable_i;

`ifdef REDIRECT_ALIGN_CHECK_EN
    assign bad_align = (jump_addr_i[1:0] != 2'b00);
`else
    assign bad_align = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RDR_IDLE;
            target_q <= `ZERO;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        misalign_d = 1'b0;
        unique case (state_q)
            RDR_IDLE: begin
                if (trap_i) begin
                    state_d  = RDR_REDIR;
                    target_d = trap_addr_i;
                end else if (accept && bad_align) begin
                    // Rejected target: the trap unit takes over.
                    misalign_d = 1'b1;
                end else if (accept) begin
                    state_d  = hold ? RDR_PEND : RDR_REDIR;
                    target_d = jump_addr_i;
                end
            end
            RDR_PEND: begin
                if (trap_i) begin
                    state_d  = RDR_REDIR;
                    target_d = trap_addr_i;
                end else if (!hold) begin
                    state_d = RDR_REDIR;
                end
            end
            RDR_REDIR: begin
                if (trap_i) begin
                    state_d  = RDR_REDIR;
                    target_d = trap_addr_i;
                end else if (FLUSH_CYCLES == 0) begin
                    state_d = RDR_IDLE;
                end else begin
                    state_d  = RDR_SHADOW;
                    cnt_load = 1'b1;
                end
            end
            RDR_SHADOW: begin
                if (trap_i) begin
                    state_d  = RDR_REDIR;
                    target_d = trap_addr_i;
                end else if (!hold_mem_i) begin
                    // The window only ages on cycles the pipe advances.
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_d = RDR_IDLE;
                    end
                end
            end
        endcase
    end

    flush_shadow_cnt u_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (cnt_load),
        .load_val (FLUSH_LD),
        .en       (cnt_en),
        .cnt      (cnt_q),
        .last     (cnt_last)
    );

`ifdef REDIRECT_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign stall_o         = hold;
    assign stall_ex_o      = hold_mem_i;
    assign redirect_o      = (state_q == RDR_REDIR);
    assign flush_o         = (state_q == RDR_REDIR) | (state_q == RDR_SHADOW);
    assign redirect_addr_o = target_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Self-checking bench for jump_redirect_ctrl (default build).
// Directed scenarios followed by random traffic against a reference model.
module tb_jump_redirect_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic        jump_enable_i;
    logic [31:0] jump_addr_i;
    logic        trap_i;
    logic [31:0] trap_addr_i;
    logic        hold_ex_i;
    logic        hold_mem_i;
    logic        stall_o;
    logic        stall_ex_o;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic        flush_o;
    logic        misalign_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending flag, one-shot redirect, shadow cycles left.
    bit          m_redir;
    bit          m_pend;
    int          m_shadow;
    logic [31:0] m_tgt;

    jump_redirect_ctrl #(
        .AW           (32),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .ex_valid_i      (ex_valid_i),
        .jump_enable_i   (jump_enable_i),
        .jump_addr_i     (jump_addr_i),
        .trap_i          (trap_i),
        .trap_addr_i     (trap_addr_i),
        .hold_ex_i       (hold_ex_i),
        .hold_mem_i      (hold_mem_i),
        .stall_o         (stall_o),
        .stall_ex_o      (stall_ex_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_redir  = 1'b0;
        m_pend   = 1'b0;
        m_shadow = 0;
        m_tgt    = 32'h0;
    endtask

    task automatic model_edge();
        bit hold;
        hold = hold_ex_i | hold_mem_i;
        if (trap_i) begin
            m_redir  = 1'b1;
            m_pend   = 1'b0;
            m_shadow = 0;
            m_tgt    = trap_addr_i;
        end else if (m_redir) begin
            m_redir  = 1'b0;
            m_shadow = FC;
        end else if (m_pend) begin
            if (!hold) begin
                m_pend  = 1'b0;
                m_redir = 1'b1;
            end
        end else if (m_shadow > 0) begin
            if (!hold_mem_i) m_shadow--;
        end else if (ex_valid_i && jump_enable_i) begin
            m_tgt = jump_addr_i;
            if (hold) m_pend = 1'b1;
            else m_redir = 1'b1;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_redirect"}, {31'b0, redirect_o}, {31'b0, m_redir});
        chk({tag, "_flush"}, {31'b0, flush_o},
            {31'b0, (m_redir || m_shadow > 0)});
        chk({tag, "_addr"}, redirect_addr_o, m_tgt);
        chk({tag, "_misalign"}, {31'b0, misalign_o}, 32'h0);
    endtask

    // One cycle: drive at negedge, model at posedge, check at next negedge.
    task automatic step(input bit ev, input bit je, input logic [31:0] ja,
                        input bit tr, input logic [31:0] ta,
                        input bit hx, input bit hm, input string tag);
        ex_valid_i    = ev;
        jump_enable_i = je;
        jump_addr_i   = ja;
        trap_i        = tr;
        trap_addr_i   = ta;
        hold_ex_i     = hx;
        hold_mem_i    = hm;
        #1;
        chk({tag, "_stall"}, {31'b0, stall_o}, {31'b0, (hx | hm)});
        chk({tag, "_stall_ex"}, {31'b0, stall_ex_o}, {31'b0, hm});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        int fl;
        rst_i         = 1'b1;
        ex_valid_i    = 1'b0;
        jump_enable_i = 1'b0;
        jump_addr_i   = '0;
        trap_i        = 1'b0;
        trap_addr_i   = '0;
        hold_ex_i     = 1'b0;
        hold_mem_i    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall_o}, 32'h1);
        chk("rst_stall_ex", {31'b0, stall_ex_o}, 32'h1);
        check_outs("rst");
        hold_mem_i = 1'b0;
        rst_i      = 1'b0;
        @(negedge clk);

        // Taken branch without holds.
        step(1, 1, 32'h100, 0, 0, 0, 0, "beq");
        chk("beq_redir", {31'b0, redirect_o}, 32'h1);
        chk("beq_addr", redirect_addr_o, 32'h100);
        step(1, 1, 32'h999, 0, 0, 0, 0, "beq_sh1");
        chk("beq_sh1_flush", {31'b0, flush_o}, 32'h1);
        step(1, 1, 32'h998, 0, 0, 0, 0, "beq_sh2");
        chk("beq_sh2_flush", {31'b0, flush_o}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0, "beq_done");
        chk("beq_done_flush", {31'b0, flush_o}, 32'h0);
        chk("beq_done_addr", redirect_addr_o, 32'h100);

        // Jump under a three-cycle memory hold.
        step(1, 1, 32'h200, 0, 0, 0, 1, "hold1");
        step(0, 0, 0, 0, 0, 0, 1, "hold2");
        step(0, 0, 0, 0, 0, 0, 1, "hold3");
        chk("hold_pend_redir", {31'b0, redirect_o}, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, "hold_rel");
        chk("hold_rel_redir", {31'b0, redirect_o}, 32'h1);
        chk("hold_rel_addr", redirect_addr_o, 32'h200);
        idle(3, "hold_drain");

        // Trap in the shadow window restarts it.
        step(1, 1, 32'h100, 0, 0, 0, 0, "tsh_j");
        step(0, 0, 0, 0, 0, 0, 0, "tsh_s");
        step(0, 0, 0, 1, 32'h8000_0000, 0, 0, "tsh_trap");
        chk("tsh_redir", {31'b0, redirect_o}, 32'h1);
        chk("tsh_addr", redirect_addr_o, 32'h8000_0000);
        fl = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, "tsh_tail");
            fl += int'(flush_o);
        end
        chk("tsh_window", fl, 2);

        // Trap beats a pending jump.
        step(1, 1, 32'h300, 0, 0, 1, 0, "tpd_j");
        step(0, 0, 0, 1, 32'h8000_0000, 1, 0, "tpd_trap");
        chk("tpd_addr", redirect_addr_o, 32'h8000_0000);
        chk("tpd_redir", {31'b0, redirect_o}, 32'h1);
        idle(4, "tpd_drain");
        chk("tpd_final_addr", redirect_addr_o, 32'h8000_0000);

        // Memory hold stretches the shadow window.
        step(1, 1, 32'h400, 0, 0, 0, 0, "hsh_j");
        fl = 0;
        step(0, 0, 0, 0, 0, 0, 0, "hsh_1");
        fl += int'(flush_o);
        step(0, 0, 0, 0, 0, 0, 1, "hsh_2");
        fl += int'(flush_o);
        step(0, 0, 0, 0, 0, 0, 1, "hsh_3");
        fl += int'(flush_o);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, "hsh_t");
            fl += int'(flush_o);
        end
        chk("hsh_window", fl, 4);

        // Asynchronous reset in the middle of PEND.
        step(1, 1, 32'h500, 0, 0, 1, 0, "arst_j");
        chk("arst_pend_addr", redirect_addr_o, 32'h500);
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        check_outs("arst");
        @(negedge clk);
        rst_i     = 1'b0;
        hold_ex_i = 1'b0;
        idle(2, "arst_after");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom(), $urandom_range(0, 9) == 0, $urandom(),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
